// File: rtl/spi_master_mc.sv
// spi_master_mc: parametrised SPI master, NCS chip selects, CPOL/CPHA, LSB-first,
// CS hold across frames. Optional macro: SPI_MASTER_LOOPBACK_EN (mosi->sampler).
// Ports: wb_clk_i/wb_rst_i clock + async high reset; cfg_* latched on accept;
// tx_valid/tx_ready/tx_data frame in; rx_valid/rx_data frame out; busy;
// sck/csb/mosi/mosi_oeb/miso SPI pins.
module spi_master_mc #(
  parameter int DATA_W = 8,
  parameter int NCS    = 4,
  parameter int DIV_W  = 8,
  localparam int CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [CSW-1:0]    cfg_cs_sel,
  input  logic              cfg_hold_cs,
  input  logic              cfg_loopback,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sck,
  output logic [NCS-1:0]    csb,
  output logic              mosi,
  output logic              mosi_oeb,
  input  logic              miso
);

  typedef enum logic [2:0] {
    IDLE, SETUP, XFER, GAP, HOLD
  } state_t;

  localparam int EW = $clog2(2 * DATA_W) + 1;
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W - 1);

  state_t            state;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_next;
  logic              cpol_q;
  logic              cpha_q;
  logic              lsb_q;
  logic              hold_q;
  logic [NCS-1:0]    cs_dec;
  logic              accept;
  logic              tick;
  logic              lead;
  logic              do_samp;
  logic              do_shift;
  logic              rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic loop_q;
  assign rx_bit = loop_q ? mosi : miso;
`else
  logic unused_loopback;
  assign unused_loopback = cfg_loopback;
  assign rx_bit = miso;
`endif

  function automatic logic bit_hd(
    input logic [DATA_W-1:0] d,
    input logic              lsb
  );
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] sh1(
    input logic [DATA_W-1:0] d,
    input logic              lsb
  );
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  assign accept = tx_valid && tx_ready;
  assign tick   = (cnt == '0);
  // even edge index = leading edge of the SCK pulse
  assign lead   = ~edge_cnt[0];

  assign do_samp = (state == XFER) && tick &&
                   (lead ^ cpha_q);
  // CPHA=0 already presented bit 0 in SETUP; skip the final trailing edge
  assign do_shift = (state == XFER) && tick &&
                    (cpha_q ? lead :
                     (!lead && edge_cnt != LAST));

  always_comb begin
    rx_next = rx_sh;
    if (do_samp) begin
      if (lsb_q)
        rx_next = {rx_bit, rx_sh[DATA_W-1:1]};
      else
        rx_next = {rx_sh[DATA_W-2:0], rx_bit};
    end
  end

  // out-of-range select decodes to no chip select
  always_comb begin
    cs_dec = '0;
    for (int i = 0; i < NCS; i++)
      cs_dec[i] = (cfg_cs_sel == CSW'(i));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      sck      <= 1'b0;
      csb      <= '1;
      mosi     <= 1'b0;
      mosi_oeb <= 1'b1;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
      cnt      <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      hold_q   <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
      loop_q   <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE, HOLD: begin
          tx_ready <= 1'b1;
          if (state == IDLE)
            sck <= cfg_cpol;
          if (accept) begin
            state    <= SETUP;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            mosi_oeb <= 1'b0;
            sck      <= cfg_cpol;
            cnt      <= cfg_div;
            div_q    <= cfg_div;
            cpol_q   <= cfg_cpol;
            cpha_q   <= cfg_cpha;
            lsb_q    <= cfg_lsb_first;
            hold_q   <= cfg_hold_cs;
`ifdef SPI_MASTER_LOOPBACK_EN
            loop_q   <= cfg_loopback;
`endif
            edge_cnt <= '0;
            rx_sh    <= '0;
            // a held CS keeps the select of the first frame
            if (state == IDLE)
              csb <= ~cs_dec;
            if (cfg_cpha) begin
              tx_sh <= tx_data;
            end else begin
              mosi  <= bit_hd(tx_data, cfg_lsb_first);
              tx_sh <= sh1(tx_data, cfg_lsb_first);
            end
          end else if (state == HOLD && !cfg_hold_cs) begin
            state    <= IDLE;
            csb      <= '1;
            mosi_oeb <= 1'b1;
            busy     <= 1'b0;
          end
        end
        SETUP: begin
          if (tick) begin
            state <= XFER;
            cnt   <= div_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        XFER: begin
          if (tick) begin
            cnt      <= div_q;
            sck      <= ~sck;
            edge_cnt <= edge_cnt + 1'b1;
            rx_sh    <= rx_next;
            if (do_shift) begin
              mosi  <= bit_hd(tx_sh, lsb_q);
              tx_sh <= sh1(tx_sh, lsb_q);
            end
            if (edge_cnt == LAST) begin
              state    <= GAP;
              rx_valid <= 1'b1;
              rx_data  <= rx_next;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (tick) begin
            tx_ready <= 1'b1;
            if (hold_q) begin
              state <= HOLD;
            end else begin
              state    <= IDLE;
              csb      <= '1;
              mosi_oeb <= 1'b1;
              busy     <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
